gb_timer: RTL



---
 rtl/gb_timer_pkg.sv | 27 ++
 rtl/gb_timer_div_m.sv | 41 ++++
 rtl/gb_timer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gb_timer_pkg.sv
// Shared types and helpers for the DIV/TIMA/TMA/TAC timer block.
package gb_timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_PENDING = 2'd1,
    T_RELOAD  = 2'd2
  } timer_state_t;

  localparam logic [1:0] OFF_DIV  = 2'd0;
  localparam logic [1:0] OFF_TIMA = 2'd1;
  localparam logic [1:0] OFF_TMA  = 2'd2;
  localparam logic [1:0] OFF_TAC  = 2'd3;

  // Counter bit that clocks TIMA for a given TAC clock-select field.
  function automatic logic [3:0] tac_tap(input logic [1:0] sel);
    logic [3:0] idx;
    case (sel)
      2'b00:   idx = 4'd7;
      2'b01:   idx = 4'd1;
      2'b10:   idx = 4'd3;
      default: idx = 4'd5;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/gb_timer_div_m.sv
// Free-running system counter with DIV clear and the TIMA tick falling-edge detector.
module timer_div_m
  import gb_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_wr,
  input  logic [2:0] tac,
  output logic [7:0] div,
  output logic       tick
);

  localparam int unsigned IDX_W = $clog2(CNT_W);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sig_q;
  logic             sig_next;

  // tac is the post-write TAC value, so enable/tap changes can glitch a tick.
  always_comb begin
    cnt_next = div_wr ? '0 : cnt + CNT_W'(1);
    sig_next = tac[2] & cnt_next[IDX_W'(tac_tap(tac[1:0]))];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sig_q <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      sig_q <= sig_next;
    end
  end

  assign tick = sig_q & ~sig_next;
  assign div  = cnt[CNT_W-1 -: 8];

endmodule

// File: rtl/gb_timer.sv
// Memory-mapped DIV/TIMA/TMA/TAC timer with overflow reload sequence and interrupt pulse.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFF04,
  parameter int unsigned CNT_W = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        write,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        irq
);

  timer_state_t state, state_next;
  logic [7:0]   tima, tima_next;
  logic [7:0]   tma, tma_next;
  logic [2:0]   tac, tac_next;
  logic         irq_next;
  logic [15:0]  off;
  logic [1:0]   sel;
  logic         wr_en;
  logic         div_wr, tima_wr, tma_wr, tac_wr;
  logic [7:0]   div;
  logic         tick;

  // Address decode; the subtraction keeps the window test to one compare.
  always_comb begin
    off     = addr - BASE;
    hit     = (off < 16'd4);
    sel     = off[1:0];
    wr_en   = write & hit;
    div_wr  = wr_en && (sel == OFF_DIV);
    tima_wr = wr_en && (sel == OFF_TIMA);
    tma_wr  = wr_en && (sel == OFF_TMA);
    tac_wr  = wr_en && (sel == OFF_TAC);
  end

  always_comb begin
    rdata = 8'hFF;
    if (hit) begin
      case (sel)
        OFF_DIV:  rdata = div;
        OFF_TIMA: rdata = tima;
        OFF_TMA:  rdata = tma;
        default:  rdata = {5'b11111, tac};
      endcase
    end
  end

  always_comb begin
    tma_next = tma_wr ? wdata : tma;
    tac_next = tac_wr ? wdata[2:0] : tac;
  end

  timer_div_m #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .div_wr (div_wr),
    .tac    (tac_next),
    .div    (div),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T_IDLE;
      tima  <= 8'h00;
      tma   <= 8'h00;
      tac   <= 3'b000;
      irq   <= 1'b0;
    end else begin
      state <= state_next;
      tima  <= tima_next;
      tma   <= tma_next;
      tac   <= tac_next;
      irq   <= irq_next;
    end
  end

  // Overflow sequence: TIMA sits at 00 for one clk, then reloads from TMA with irq.
  always_comb begin
    state_next = state;
    tima_next  = tima;
    irq_next   = 1'b0;
    case (state)
      T_IDLE: begin
        if (tima_wr) begin
          tima_next = wdata;
        end else if (tick) begin
          if (tima == 8'hFF) begin
            tima_next  = 8'h00;
            state_next = T_PENDING;
          end else begin
            tima_next = tima + 8'd1;
          end
        end
      end
      T_PENDING: begin
        if (tima_wr) begin
          tima_next  = wdata;
          state_next = T_IDLE;
        end else begin
          tima_next  = tma_next;
          irq_next   = 1'b1;
          state_next = T_RELOAD;
        end
      end
      T_RELOAD: begin
        tima_next  = tma_next + {7'd0, tick};
        state_next = T_IDLE;
      end
      default: begin
        state_next = T_IDLE;
      end
    endcase
  end

endmodule
